pe_net_injector: RTL and testbench
==================================

PE_NET_INJECTOR -- requirements
Module: pe_net_injector

Interface
REQ-001 Parameters, one per line (name, default, meaning); SHALL be overridable per instance:
- DataWidth, 8, NoC flit width; SHALL satisfy DataWidth >= 2*AddrWidth+4.
- AddrWidth, 2, row/col address width.
- ViChAddr, 1, virtual-channel select width.
- FifoDepth, 4, payload FIFO entries; SHALL be a power of two.
REQ-002 Ports, one per line (name, direction, width, meaning); clock and reset first:
- clock, in, 1, single clock; all state rising-edge.
- reset, in, 1, asynchronous active-low reset.
- msg_valid, in, 1, core offers a packet command.
- msg_ready, out, 1, command accepted when msg_valid&msg_ready.
- msg_row, in, AddrWidth, destination row.
- msg_col, in, AddrWidth, destination column.
- msg_len, in, 4, payload flit count 0..15.
- msg_vc, in, ViChAddr, virtual channel for the packet.
- word_valid, in, 1, core offers a payload word.
- word_ready, out, 1, word accepted when word_valid&word_ready.
- word_data, in, DataWidth, payload word.
- OutpData, out, DataWidth, flit to NoC PE port.
- OutpEn, out, 1, flit valid.
- OutpReady, in, 1, NoC accepts; transfer = OutpEn&OutpReady in the same cycle.
- OutpSel, out, ViChAddr, virtual channel of the current flit.
- busy, out, 1, high when FSM is not IDLE.
- pkt_count, out, 16, packets fully sent; wraps 0xFFFF->0x0000.

Function
REQ-003 FSM states: IDLE, HEAD, BODY.
REQ-004 IDLE: msg_ready=1; on msg_valid, latch row/col/len/vc and go to HEAD next cycle.
REQ-005 HEAD: OutpEn=1; OutpData={zero-pad, len[3:0], row, col}, col in LSBs; on transfer go to BODY if len!=0, else IDLE with pkt_count+1.
REQ-006 Header SHALL appear on OutpEn exactly 1 cycle after command acceptance.
REQ-007 BODY: OutpEn = FIFO not empty; OutpData = FIFO head; each transfer pops one word and decrements the remaining count.
REQ-008 BODY: on transfer of the last word (remaining==1), go to IDLE and increment pkt_count in that cycle.
REQ-009 msg_ready SHALL be 0 in HEAD and BODY; no command queuing.
REQ-010 OutpSel SHALL hold the latched vc in HEAD and BODY, and 0 in IDLE.
REQ-011 OutpEn, OutpData and OutpSel SHALL remain stable while OutpEn=1 and OutpReady=0.
REQ-012 FIFO: word_ready = not full; it SHALL accept words in any state, including prefetch in IDLE.
REQ-013 FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; no push when full, no pop when empty; pointers wrap modulo FifoDepth.
REQ-014 OutpEn=0 in IDLE; OutpData=0 whenever OutpEn=0.
REQ-015 The FIFO is not flushed at packet end; surplus words belong to the next packet.

Reset
REQ-016 reset low SHALL asynchronously force IDLE, empty the FIFO, and clear pkt_count and latched fields.
REQ-017 During reset, outputs SHALL be: OutpEn=0, OutpData=0, OutpSel=0, msg_ready=0, word_ready=0, busy=0.
REQ-018 After reset deasserts, msg_ready and word_ready SHALL rise on the first clock edge.
REQ-019 Reset mid-packet SHALL abort the packet without incrementing pkt_count.

Structure
REQ-020 Shared package noc_pkg SHALL hold the state enum and the header field offsets/width constants.
REQ-021 The payload FIFO SHALL be sub-module pe_inj_fifo (parameters DataWidth, FifoDepth; outputs full, empty).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Cmd row=1 col=2 len=3 vc=1 with words 0xA1,0xA2,0xA3 preloaded, OutpReady=1 -> flits 0x36,0xA1,0xA2,0xA3 on 4 consecutive cycles, OutpSel=1, pkt_count=1.
- len=0, row=3 col=3 -> single flit 0x0F, then IDLE, pkt_count+1, FIFO untouched.
- OutpReady low for 5 cycles during BODY -> OutpData held constant, no pop, no loss.
- 5 words pushed with depth 4 and no command -> word_ready=0 after the 4th; a command len=4 then drains FIFO in order and word_ready rises.
- Reset low after header plus 1 body flit of a len=3 packet -> OutpEn=0 immediately, FIFO empty, pkt_count unchanged, next packet correct.
- pkt_count preset to 0xFFFF via 65535 len=0 packets, then one more packet -> pkt_count=0x0000.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the PE network injector: FSM states and the
// layout of the header flit ({zero-pad, len, row, col}, col in the LSBs).
package noc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } inj_state_e;

    // Payload length field and packet counter widths.
    localparam int LEN_WIDTH   = 4;
    localparam int CNT_WIDTH   = 16;

    // Column always sits at bit 0 of the header.
    localparam int HDR_COL_OFS = 0;

    // Row follows the column field.
    function automatic int hdr_row_ofs(input int addr_width);
        return addr_width;
    endfunction

    // Length follows the row field.
    function automatic int hdr_len_ofs(input int addr_width);
        return 2 * addr_width;
    endfunction

    // Number of meaningful header bits; the flit width must cover this.
    function automatic int hdr_width(input int addr_width);
        return 2 * addr_width + LEN_WIDTH;
    endfunction

endpackage

// File: rtl/pe_inj_fifo.sv
// Payload FIFO for the injector. Show-ahead: pop_data is the current head
// whenever empty is low. Pointers carry one extra wrap bit so full and empty
// are told apart; FifoDepth must be a power of two.
module pe_inj_fifo #(
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic [DataWidth-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);

    localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    logic [PtrWidth:0]    wr_ptr_q;
    logic [PtrWidth:0]    wr_ptr_d;
    logic [PtrWidth:0]    rd_ptr_q;
    logic [PtrWidth:0]    rd_ptr_d;
    logic                 do_push;
    logic                 do_pop;
    logic [DataWidth-1:0] mem_q [FifoDepth];

    // Status flags, guarded push/pop and next pointer values.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                   (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{PtrWidth{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PtrWidth{1'b0}}, do_pop};
        pop_data = mem_q[rd_ptr_q[PtrWidth-1:0]];
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrWidth-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pe_net_injector.sv
// Packet injector from a processing element into the NoC. A command
// (row/col/len/vc) produces one header flit followed by len payload flits
// taken from the payload FIFO, which the core may fill at any time.
module pe_net_injector
    import noc_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 2,
    parameter int ViChAddr  = 1,
    parameter int FifoDepth = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [AddrWidth-1:0] msg_row,
    input  logic [AddrWidth-1:0] msg_col,
    input  logic [3:0]           msg_len,
    input  logic [ViChAddr-1:0]  msg_vc,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic [DataWidth-1:0] word_data,
    output logic [DataWidth-1:0] OutpData,
    output logic                 OutpEn,
    input  logic                 OutpReady,
    output logic [ViChAddr-1:0]  OutpSel,
    output logic                 busy,
    output logic [15:0]          pkt_count
);

    localparam int RowOfs = hdr_row_ofs(AddrWidth);
    localparam int LenOfs = hdr_len_ofs(AddrWidth);

    inj_state_e               state_q;
    inj_state_e               state_d;
    logic [AddrWidth-1:0]     row_q;
    logic [AddrWidth-1:0]     row_d;
    logic [AddrWidth-1:0]     col_q;
    logic [AddrWidth-1:0]     col_d;
    logic [LEN_WIDTH-1:0]     len_q;      // header length in HEAD, words left in BODY
    logic [LEN_WIDTH-1:0]     len_d;
    logic [ViChAddr-1:0]      vc_q;
    logic [ViChAddr-1:0]      vc_d;
    logic [CNT_WIDTH-1:0]     pkt_count_q;
    logic [CNT_WIDTH-1:0]     pkt_count_d;
    logic                     live_q;     // low in reset and until the first edge after it
    logic                     live_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [DataWidth-1:0]     fifo_head;
    logic [DataWidth-1:0]     header;
    logic                     xfer;
    logic                     accept;

    pe_inj_fifo #(
        .DataWidth (DataWidth),
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (word_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Handshakes and NoC-side outputs decoded from the current state.
    always_comb begin
        msg_ready  = live_q && (state_q == ST_IDLE);
        word_ready = live_q && !fifo_full;
        accept     = msg_valid && msg_ready;
        fifo_push  = word_valid && word_ready;

        header = '0;
        header[HDR_COL_OFS +: AddrWidth] = col_q;
        header[RowOfs +: AddrWidth]      = row_q;
        header[LenOfs +: LEN_WIDTH]      = len_q;

        OutpEn   = 1'b0;
        OutpData = '0;
        case (state_q)
            ST_HEAD: begin
                OutpEn   = 1'b1;
                OutpData = header;
            end
            ST_BODY: begin
                OutpEn   = !fifo_empty;
                OutpData = fifo_empty ? '0 : fifo_head;
            end
            default: begin
                OutpEn   = 1'b0;
                OutpData = '0;
            end
        endcase

        OutpSel   = (state_q == ST_IDLE) ? '0 : vc_q;
        busy      = (state_q != ST_IDLE);
        pkt_count = pkt_count_q;
        xfer      = OutpEn && OutpReady;
        fifo_pop  = (state_q == ST_BODY) && xfer;
    end

    // Next-state: latch the command, walk header then body, count finished packets.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        len_d       = len_q;
        vc_d        = vc_q;
        pkt_count_d = pkt_count_q;
        live_d      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    row_d   = msg_row;
                    col_d   = msg_col;
                    len_d   = msg_len;
                    vc_d    = msg_vc;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (xfer) begin
                    if (len_q != '0) begin
                        state_d = ST_BODY;
                    end else begin
                        state_d     = ST_IDLE;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    len_d = len_q - 4'd1;
                    if (len_q == 4'd1) begin
                        state_d     = ST_IDLE;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched command fields; reset aborts any packet in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            len_q       <= '0;
            vc_q        <= '0;
            pkt_count_q <= '0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            len_q       <= len_d;
            vc_q        <= vc_d;
            pkt_count_q <= pkt_count_d;
            live_q      <= live_d;
        end
    end

endmodule

// File: tb/tb_pe_net_injector.sv
// Directed bench for pe_net_injector. Inputs change just after a falling
// edge; outputs are sampled 1 time unit later, well before the rising edge.
module tb_pe_net_injector;

    logic       clock;
    logic       reset;
    logic       msg_valid;
    logic       msg_ready;
    logic [1:0] msg_row;
    logic [1:0] msg_col;
    logic [3:0] msg_len;
    logic [0:0] msg_vc;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] word_data;
    logic [7:0] OutpData;
    logic       OutpEn;
    logic       OutpReady;
    logic [0:0] OutpSel;
    logic       busy;
    logic [15:0] pkt_count;

    int n_vec  = 0;
    int n_miss = 0;

    pe_net_injector #(
        .DataWidth (8),
        .AddrWidth (2),
        .ViChAddr  (1),
        .FifoDepth (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_row    (msg_row),
        .msg_col    (msg_col),
        .msg_len    (msg_len),
        .msg_vc     (msg_vc),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .OutpData   (OutpData),
        .OutpEn     (OutpEn),
        .OutpReady  (OutpReady),
        .OutpSel    (OutpSel),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the design wedges.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One payload word offered and accepted.
    task automatic push_word(input logic [7:0] d);
        word_valid = 1'b1;
        word_data  = d;
        #1;
        chk_eq("push_ready", {31'd0, word_ready}, 32'd1);
        @(negedge clock);
        word_valid = 1'b0;
    endtask

    // One command offered in IDLE and accepted on the next rising edge.
    task automatic send_cmd(input logic [1:0] row, input logic [1:0] col,
                            input logic [3:0] len, input logic vc);
        msg_valid = 1'b1;
        msg_row   = row;
        msg_col   = col;
        msg_len   = len;
        msg_vc    = vc;
        #1;
        chk_eq("cmd_ready", {31'd0, msg_ready}, 32'd1);
        @(negedge clock);
        msg_valid = 1'b0;
    endtask

    // Expect a valid flit this cycle, with OutpReady driven as given.
    task automatic flit(input string tag, input logic [7:0] exp_data,
                        input logic exp_sel, input logic rdy);
        OutpReady = rdy;
        #1;
        chk_eq({tag, "_en"},   {31'd0, OutpEn},    32'd1);
        chk_eq({tag, "_data"}, {24'd0, OutpData},  {24'd0, exp_data});
        chk_eq({tag, "_sel"},  {31'd0, OutpSel},   {31'd0, exp_sel});
        chk_eq({tag, "_busy"}, {31'd0, busy},      32'd1);
        chk_eq({tag, "_mrdy"}, {31'd0, msg_ready}, 32'd0);
        @(negedge clock);
    endtask

    // Expect the idle output set and a given packet count.
    task automatic idle_chk(input string tag, input logic [15:0] exp_cnt, input logic exp_wr);
        #1;
        chk_eq({tag, "_en"},   {31'd0, OutpEn},     32'd0);
        chk_eq({tag, "_data"}, {24'd0, OutpData},   32'd0);
        chk_eq({tag, "_sel"},  {31'd0, OutpSel},    32'd0);
        chk_eq({tag, "_busy"}, {31'd0, busy},       32'd0);
        chk_eq({tag, "_mrdy"}, {31'd0, msg_ready},  32'd1);
        chk_eq({tag, "_wrdy"}, {31'd0, word_ready}, {31'd0, exp_wr});
        chk_eq({tag, "_cnt"},  {16'd0, pkt_count},  {16'd0, exp_cnt});
        $display("txn %s: idle, pkt_count=0x%04h", tag, pkt_count);
        @(negedge clock);
    endtask

    // Outputs forced by an active reset.
    task automatic reset_chk(input string tag);
        chk_eq({tag, "_en"},   {31'd0, OutpEn},     32'd0);
        chk_eq({tag, "_data"}, {24'd0, OutpData},   32'd0);
        chk_eq({tag, "_sel"},  {31'd0, OutpSel},    32'd0);
        chk_eq({tag, "_mrdy"}, {31'd0, msg_ready},  32'd0);
        chk_eq({tag, "_wrdy"}, {31'd0, word_ready}, 32'd0);
        chk_eq({tag, "_busy"}, {31'd0, busy},       32'd0);
        chk_eq({tag, "_cnt"},  {16'd0, pkt_count},  32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        msg_valid  = 1'b0;
        msg_row    = '0;
        msg_col    = '0;
        msg_len    = '0;
        msg_vc     = '0;
        word_valid = 1'b0;
        word_data  = '0;
        OutpReady  = 1'b1;

        // Reset state, and readiness only after the first edge post-release.
        #1;
        reset_chk("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_eq("rel_mrdy_pre", {31'd0, msg_ready},  32'd0);
        chk_eq("rel_wrdy_pre", {31'd0, word_ready}, 32'd0);
        @(negedge clock);
        idle_chk("rel", 16'h0000, 1'b1);

        // Scenario 1: row1 col2 len3 vc1, three words preloaded.
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        send_cmd(2'd1, 2'd2, 4'd3, 1'b1);
        flit("s1_hdr", 8'h36, 1'b1, 1'b1);
        flit("s1_w0",  8'hA1, 1'b1, 1'b1);
        flit("s1_w1",  8'hA2, 1'b1, 1'b1);
        flit("s1_w2",  8'hA3, 1'b1, 1'b1);
        idle_chk("s1", 16'd1, 1'b1);

        // Scenario 2: len0 packet with a word waiting in the FIFO.
        push_word(8'h55);
        send_cmd(2'd3, 2'd3, 4'd0, 1'b0);
        flit("s2_hdr", 8'h0F, 1'b0, 1'b1);
        idle_chk("s2", 16'd2, 1'b1);

        // Scenario 3: the waiting word leads the next packet; 5-cycle stall.
        push_word(8'h66);
        send_cmd(2'd0, 2'd1, 4'd2, 1'b1);
        flit("s3_hdr", 8'h21, 1'b1, 1'b1);
        flit("s3_w0",  8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            flit("s3_stall", 8'h66, 1'b1, 1'b0);
        end
        flit("s3_w1", 8'h66, 1'b1, 1'b1);
        idle_chk("s3", 16'd3, 1'b1);

        // Scenario 4: fill to depth, fifth word refused, then drain in order.
        push_word(8'hB1);
        push_word(8'hB2);
        push_word(8'hB3);
        push_word(8'hB4);
        word_valid = 1'b1;
        word_data  = 8'hB5;
        #1;
        chk_eq("s4_full_wrdy", {31'd0, word_ready}, 32'd0);
        @(negedge clock);
        word_valid = 1'b0;
        send_cmd(2'd2, 2'd1, 4'd4, 1'b0);
        flit("s4_hdr", 8'h49, 1'b0, 1'b1);
        flit("s4_w0",  8'hB1, 1'b0, 1'b1);
        flit("s4_w1",  8'hB2, 1'b0, 1'b1);
        flit("s4_w2",  8'hB3, 1'b0, 1'b1);
        flit("s4_w3",  8'hB4, 1'b0, 1'b1);
        idle_chk("s4", 16'd4, 1'b1);

        // Scenario 5: reset after header plus one body flit of a len3 packet.
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        send_cmd(2'd1, 2'd1, 4'd3, 1'b1);
        flit("s5_hdr", 8'h35, 1'b1, 1'b1);
        flit("s5_w0",  8'hC1, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        // Reset clears the counter; the aborted packet is never counted.
        reset_chk("s5_rst");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        idle_chk("s5_rel", 16'd0, 1'b1);
        // If C2/C3 survived, D1 would not be the first body word.
        push_word(8'hD1);
        send_cmd(2'd0, 2'd0, 4'd1, 1'b0);
        flit("s5n_hdr", 8'h10, 1'b0, 1'b1);
        flit("s5n_w0",  8'hD1, 1'b0, 1'b1);
        idle_chk("s5n", 16'd1, 1'b1);

        // Scenario 6: 65535 back-to-back len0 packets, then one more wraps.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        OutpReady = 1'b1;
        msg_row   = 2'd0;
        msg_col   = 2'd0;
        msg_len   = 4'd0;
        msg_vc    = 1'b0;
        msg_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clock);
            @(negedge clock);
        end
        msg_valid = 1'b0;
        idle_chk("s6_pre", 16'hFFFF, 1'b1);
        send_cmd(2'd2, 2'd2, 4'd0, 1'b1);
        flit("s6_hdr", 8'h0A, 1'b1, 1'b1);
        idle_chk("s6_wrap", 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
